// File: rtl/issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// issue_scheduler_if
// Bundles the fetch-side enqueue handshake, the downstream control inputs and
// the registered issue ports of the issue scheduler.
//
//   in_valid1/in_valid2   : fetched instruction valids (valid2 needs valid1)
//   in_instr1/in_instr2   : fetched instructions, program order 1 then 2
//   in_pc                 : PC of in_instr1 (in_instr2 sits at in_pc+4)
//   in_ready              : at least two free queue entries
//   stall / flush         : downstream hold / redirect
//   issue{1,2}_valid/instr/pc : registered issue slots toward decode
//   count                 : queue occupancy
//   split_count           : cycles where a pair was available but not issued
//
// master: fetch/decode side (drives inputs). slave: the scheduler.
// -----------------------------------------------------------------------------
interface issue_scheduler_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid1;
    logic          in_valid2;
    logic [31:0]   in_instr1;
    logic [31:0]   in_instr2;
    logic [31:0]   in_pc;
    logic          in_ready;
    logic          stall;
    logic          flush;
    logic          issue1_valid;
    logic          issue2_valid;
    logic [31:0]   issue1_instr;
    logic [31:0]   issue2_instr;
    logic [31:0]   issue1_pc;
    logic [31:0]   issue2_pc;
    logic [CW-1:0] count;
    logic [31:0]   split_count;

    modport master (
        output in_valid1, in_valid2, in_instr1, in_instr2, in_pc, stall, flush,
        input  in_ready, issue1_valid, issue2_valid, issue1_instr, issue2_instr,
               issue1_pc, issue2_pc, count, split_count
    );

    modport slave (
        input  in_valid1, in_valid2, in_instr1, in_instr2, in_pc, stall, flush,
        output in_ready, issue1_valid, issue2_valid, issue1_instr, issue2_instr,
               issue1_pc, issue2_pc, count, split_count
    );
endinterface

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
// Circular instruction queue feeding a dual-issue decode stage. Up to two
// instructions are enqueued per cycle; each cycle the two oldest entries are
// issued as a pair when they are independent, otherwise the oldest issues
// alone. Issue ports are registered. Single-issue splits are counted.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : issue_scheduler_if.slave (enqueue handshake, stall/flush, issue
//          slots, occupancy and split counter)
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    issue_scheduler_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // Instruction classification (MIPS-style encodings)
    // ------------------------------------------------------------------
    function automatic logic is_ctrl(input logic [31:0] ins);
        return (ins[31:26] == 6'h04) || (ins[31:26] == 6'h05) ||
               (ins[31:26] == 6'h02) || (ins[31:26] == 6'h03) ||
               ((ins[31:26] == 6'h00) && (ins[5:0] == 6'h08));
    endfunction

    function automatic logic is_mem(input logic [31:0] ins);
        return (ins[31:26] == 6'h23) || (ins[31:26] == 6'h2B);
    endfunction

    // Returns 0 when the instruction writes no register ($0 is never a hazard).
    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        if ((ins[31:26] == 6'h00) && (ins[5:0] != 6'h08)) return ins[15:11];
        else if (ins[31:26] == 6'h03)                     return 5'd31;
        else if ((ins[31:26] == 6'h23) || (ins[31:29] == 3'b001))
                                                          return ins[20:16];
        else                                              return 5'd0;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          v1_q, v1_d, v2_q, v2_d;
    logic [31:0]   i1_q, i1_d, i2_q, i2_d, pc1_q, pc1_d, pc2_q, pc2_d;
    logic [31:0]   split_q, split_d;

    logic [CW-1:0] enq_cnt, deq_cnt;
    logic          in_ready_w, enq, pair_ok;
    entry_t        ent_a, ent_b;
    logic [4:0]    dest_a, dest_b;

    // Free entries >= 2 looks only at the registered occupancy, so a dequeue
    // in the same cycle cannot raise it.
    assign in_ready_w = (occ_q <= CW'(DEPTH - 2));
    assign enq        = bus.in_valid1 & in_ready_w & ~bus.flush;

    assign ent_a  = mem_q[head_q];
    assign ent_b  = mem_q[head_q + PW'(1)];
    assign dest_a = dest_of(ent_a.instr);
    assign dest_b = dest_of(ent_b.instr);

    // B's rs and rt are both compared against A's destination regardless of
    // B's format; this may reject some legal pairs but never a hazard.
    assign pair_ok = (occ_q >= CW'(2))
                   & ~is_ctrl(ent_a.instr) & ~is_ctrl(ent_b.instr)
                   & ~(is_mem(ent_a.instr) & is_mem(ent_b.instr))
                   & ((dest_a == 5'd0) |
                      ((ent_b.instr[25:21] != dest_a) & (ent_b.instr[20:16] != dest_a)))
                   & ~((dest_a != 5'd0) & (dest_a == dest_b));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        pc1_d   = pc1_q;
        pc2_d   = pc2_q;
        split_d = split_q;
        enq_cnt = '0;
        deq_cnt = '0;

        if (bus.flush) begin
            // Flush outranks stall and drops any same-cycle enqueue.
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            v1_d   = 1'b0;
            v2_d   = 1'b0;
        end else begin
            if (enq) begin
                enq_cnt = bus.in_valid2 ? CW'(2) : CW'(1);
                tail_d  = tail_q + enq_cnt[PW-1:0];
            end

            if (!bus.stall) begin
                if (occ_q == '0) begin
                    v1_d = 1'b0;
                    v2_d = 1'b0;
                end else begin
                    v1_d  = 1'b1;
                    i1_d  = ent_a.instr;
                    pc1_d = ent_a.pc;
                    if (pair_ok) begin
                        v2_d    = 1'b1;
                        i2_d    = ent_b.instr;
                        pc2_d   = ent_b.pc;
                        deq_cnt = CW'(2);
                    end else begin
                        v2_d    = 1'b0;
                        deq_cnt = CW'(1);
                        if (occ_q >= CW'(2)) split_d = split_q + 32'd1;
                    end
                end
                head_d = head_q + deq_cnt[PW-1:0];
            end

            occ_d = occ_q + enq_cnt - deq_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            i1_q    <= '0;
            i2_q    <= '0;
            pc1_q   <= '0;
            pc2_q   <= '0;
            split_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            pc1_q   <= pc1_d;
            pc2_q   <= pc2_d;
            split_q <= split_d;
        end
    end

    // NOTE: the queue storage has no reset; occupancy alone decides which
    // entries are live, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem_q[tail_q] <= '{instr: bus.in_instr1, pc: bus.in_pc};
            if (bus.in_valid2)
                mem_q[tail_q + PW'(1)] <= '{instr: bus.in_instr2, pc: bus.in_pc + 32'd4};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready     = in_ready_w;
    assign bus.issue1_valid = v1_q;
    assign bus.issue2_valid = v2_q;
    assign bus.issue1_instr = i1_q;
    assign bus.issue2_instr = i2_q;
    assign bus.issue1_pc    = pc1_q;
    assign bus.issue2_pc    = pc2_q;
    assign bus.count        = occ_q;
    assign bus.split_count  = split_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
// Directed, table-driven bench for issue_scheduler (DEPTH = 8). Each table row
// holds the inputs for one clock edge and the outputs expected just after it.
// A short hand-written sequence follows for the valid2-without-valid1 case and
// single-instruction enqueue.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;
    localparam int DEPTH = 8;

    localparam logic [31:0] ADD3 = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] ADD6 = 32'h00223020;  // add $6,$1,$2
    localparam logic [31:0] RAW  = 32'h00642820;  // add $5,$3,$4
    localparam logic [31:0] LW   = 32'h8D280000;  // lw  $8,0($9)
    localparam logic [31:0] SW   = 32'hAD480004;  // sw  $8,4($10)
    localparam logic [31:0] BEQ  = 32'h10220004;  // beq $1,$2,+4

    logic clk = 1'b0;
    logic rst = 1'b1;

    issue_scheduler_if #(.DEPTH(DEPTH)) bus ();

    issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, stall, flush, v1, v2;
        logic [31:0] i1, i2, pc;
        logic        e_ready;
        logic [3:0]  e_count;
        logic [31:0] e_split;
        logic        e_v1;
        logic [31:0] e_i1, e_pc1;
        logic        e_v2;
        logic [31:0] e_i2, e_pc2;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;
    int   n_vec  = 0;
    int   n_miss = 0;

    // add $rd,$1,$2 : independent of every other such add with rd not 1/2
    function automatic logic [31:0] xadd(input int rd);
        return 32'h00220020 | (32'(rd) << 11);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic stim(input logic r, s, f, a1, a2, input logic [31:0] i1, i2, pc);
        cur       = '0;
        cur.rst   = r;
        cur.stall = s;
        cur.flush = f;
        cur.v1    = a1;
        cur.v2    = a2;
        cur.i1    = i1;
        cur.i2    = i2;
        cur.pc    = pc;
    endtask

    task automatic idle();
        stim(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic expect_o(input logic rdy, input logic [3:0] cnt, input logic [31:0] spl,
                            input logic ev1, input logic [31:0] ei1, ep1,
                            input logic ev2, input logic [31:0] ei2, ep2);
        cur.e_ready = rdy;
        cur.e_count = cnt;
        cur.e_split = spl;
        cur.e_v1    = ev1;
        cur.e_i1    = ei1;
        cur.e_pc1   = ep1;
        cur.e_v2    = ev2;
        cur.e_i2    = ei2;
        cur.e_pc2   = ep2;
        tbl.push_back(cur);
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.stall     = v.stall;
        bus.flush     = v.flush;
        bus.in_valid1 = v.v1;
        bus.in_valid2 = v.v2;
        bus.in_instr1 = v.i1;
        bus.in_instr2 = v.i2;
        bus.in_pc     = v.pc;
    endtask

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.in_valid1 = 1'b0; bus.in_valid2 = 1'b0;
        bus.in_instr1 = '0; bus.in_instr2 = '0; bus.in_pc = '0;

        // ---------------- vector table ----------------
        // 0: reset
        stim(1, 0, 0, 0, 0, 0, 0, 0);                   expect_o(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // 1-2: independent pair issues together
        stim(0, 0, 0, 1, 1, ADD3, ADD6, 32'h100);       expect_o(1, 2, 0, 0, 0, 0, 0, 0, 0);
        idle();                                         expect_o(1, 0, 0, 1, ADD3, 32'h100, 1, ADD6, 32'h104);
        // 3-5: RAW on $3 splits
        stim(0, 0, 0, 1, 1, ADD3, RAW, 32'h200);        expect_o(1, 2, 0, 0, 0, 0, 0, 0, 0);
        idle();                                         expect_o(1, 1, 1, 1, ADD3, 32'h200, 0, 0, 0);
        idle();                                         expect_o(1, 0, 1, 1, RAW, 32'h204, 0, 0, 0);
        // 6-10: lw+sw split; beq issues alone, enqueue overlaps a dequeue
        stim(0, 0, 0, 1, 1, LW, SW, 32'h300);           expect_o(1, 2, 1, 0, 0, 0, 0, 0, 0);
        idle();                                         expect_o(1, 1, 2, 1, LW, 32'h300, 0, 0, 0);
        stim(0, 0, 0, 1, 1, BEQ, ADD6, 32'h400);        expect_o(1, 2, 2, 1, SW, 32'h304, 0, 0, 0);
        idle();                                         expect_o(1, 1, 3, 1, BEQ, 32'h400, 0, 0, 0);
        idle();                                         expect_o(1, 0, 3, 1, ADD6, 32'h404, 0, 0, 0);
        // 11: empty queue -> bubble
        idle();                                         expect_o(1, 0, 3, 0, 0, 0, 0, 0, 0);
        // 12-17: fill under stall, outputs frozen, full inputs ignored
        stim(0, 0, 0, 1, 1, xadd(10), xadd(11), 32'h500); expect_o(1, 2, 3, 0, 0, 0, 0, 0, 0);
        stim(0, 0, 0, 1, 1, xadd(12), xadd(13), 32'h508); expect_o(1, 2, 3, 1, xadd(10), 32'h500, 1, xadd(11), 32'h504);
        stim(0, 1, 0, 1, 1, xadd(14), xadd(15), 32'h510); expect_o(1, 4, 3, 1, xadd(10), 32'h500, 1, xadd(11), 32'h504);
        stim(0, 1, 0, 1, 1, xadd(16), xadd(17), 32'h518); expect_o(1, 6, 3, 1, xadd(10), 32'h500, 1, xadd(11), 32'h504);
        stim(0, 1, 0, 1, 1, xadd(18), xadd(19), 32'h520); expect_o(0, 8, 3, 1, xadd(10), 32'h500, 1, xadd(11), 32'h504);
        stim(0, 1, 0, 1, 1, xadd(20), xadd(21), 32'h528); expect_o(0, 8, 3, 1, xadd(10), 32'h500, 1, xadd(11), 32'h504);
        // 18-22: release stall, in-order drain across the pointer wrap
        idle(); expect_o(1, 6, 3, 1, xadd(12), 32'h508, 1, xadd(13), 32'h50C);
        idle(); expect_o(1, 4, 3, 1, xadd(14), 32'h510, 1, xadd(15), 32'h514);
        idle(); expect_o(1, 2, 3, 1, xadd(16), 32'h518, 1, xadd(17), 32'h51C);
        idle(); expect_o(1, 0, 3, 1, xadd(18), 32'h520, 1, xadd(19), 32'h524);
        idle(); expect_o(1, 0, 3, 0, 0, 0, 0, 0, 0);
        // 23-27: five entries queued, flush (with stall) plus same-cycle enqueue
        stim(0, 1, 0, 1, 1, xadd(10), xadd(11), 32'h600); expect_o(1, 2, 3, 0, 0, 0, 0, 0, 0);
        stim(0, 1, 0, 1, 1, xadd(12), xadd(13), 32'h608); expect_o(1, 4, 3, 0, 0, 0, 0, 0, 0);
        stim(0, 1, 0, 1, 0, xadd(14), xadd(15), 32'h610); expect_o(1, 5, 3, 0, 0, 0, 0, 0, 0);
        stim(0, 1, 1, 1, 1, xadd(15), xadd(16), 32'h700); expect_o(1, 0, 3, 0, 0, 0, 0, 0, 0);
        idle();                                           expect_o(1, 0, 3, 0, 0, 0, 0, 0, 0);
        // 28-31: reset mid-stream with stall asserted
        stim(0, 0, 0, 1, 1, ADD3, RAW, 32'h800);        expect_o(1, 2, 3, 0, 0, 0, 0, 0, 0);
        stim(0, 0, 0, 1, 1, LW, SW, 32'h900);           expect_o(1, 3, 4, 1, ADD3, 32'h800, 0, 0, 0);
        stim(1, 1, 0, 1, 1, xadd(10), xadd(11), 32'hA00); expect_o(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();                                         expect_o(1, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
            check($sformatf("v%0d count", i), 32'(bus.count), 32'(tbl[i].e_count));
            check($sformatf("v%0d split_count", i), bus.split_count, tbl[i].e_split);
            check($sformatf("v%0d issue1_valid", i), 32'(bus.issue1_valid), 32'(tbl[i].e_v1));
            check($sformatf("v%0d issue2_valid", i), 32'(bus.issue2_valid), 32'(tbl[i].e_v2));
            if (tbl[i].e_v1) begin
                check($sformatf("v%0d issue1_instr", i), bus.issue1_instr, tbl[i].e_i1);
                check($sformatf("v%0d issue1_pc", i), bus.issue1_pc, tbl[i].e_pc1);
            end
            if (tbl[i].e_v2) begin
                check($sformatf("v%0d issue2_instr", i), bus.issue2_instr, tbl[i].e_i2);
                check($sformatf("v%0d issue2_pc", i), bus.issue2_pc, tbl[i].e_pc2);
            end
            if (tbl[i].rst) begin
                check($sformatf("v%0d rst issue1_instr", i), bus.issue1_instr, 32'h0);
                check($sformatf("v%0d rst issue2_pc", i), bus.issue2_pc, 32'h0);
            end
        end

        // ---------------- hand-written sequence ----------------
        // in_valid2 without in_valid1 enqueues nothing.
        @(negedge clk);
        bus.in_valid1 = 1'b0; bus.in_valid2 = 1'b1;
        bus.in_instr1 = ADD3; bus.in_instr2 = ADD6; bus.in_pc = 32'hB00;
        @(posedge clk); #1;
        check("valid2_only count", 32'(bus.count), 32'd0);

        // Single enqueue, then bounded wait for it to reach slot 1 alone.
        @(negedge clk);
        bus.in_valid1 = 1'b1; bus.in_valid2 = 1'b0;
        bus.in_instr1 = ADD6; bus.in_pc = 32'hC00;
        @(posedge clk); #1;
        check("single count", 32'(bus.count), 32'd1);
        @(negedge clk);
        bus.in_valid1 = 1'b0;
        begin
            int waited = 0;
            @(posedge clk); #1;
            while (!bus.issue1_valid && waited < 8) begin
                @(posedge clk); #1;
                waited++;
            end
            check("single issue1_valid", 32'(bus.issue1_valid), 32'd1);
            check("single issue1_instr", bus.issue1_instr, ADD6);
            check("single issue1_pc", bus.issue1_pc, 32'hC00);
            check("single issue2_valid", 32'(bus.issue2_valid), 32'd0);
            check("single split_count", bus.split_count, 32'd0);
            check("single drained count", 32'(bus.count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Instruction queue and pair-issue controller in front of the dual-issue decode stage. Accepts up to two fetched instructions per cycle into a circular buffer. Each cycle it decides whether the two oldest entries can issue together (slot 1 + slot 2) or only the oldest alone (slot 1), then presents them on registered issue ports that drive the decode stage's `instruction1`/`instruction2`. It also counts single-issue splits for performance analysis.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥4. Pointer width log2(DEPTH); occupancy width log2(DEPTH)+1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid1` in 1: `in_instr1` valid.
- `in_valid2` in 1: `in_instr2` valid; ignored unless `in_valid1`=1.
- `in_instr1`, `in_instr2` in 32: fetched instructions, program order 1 then 2.
- `in_pc` in 32: PC of `in_instr1`. The PC of `in_instr2` is `in_pc+4`.
- `in_ready` out 1: free entries ≥2; combinational from occupancy register.
- `stall` in 1: downstream hazard stall; hold issue outputs, no dequeue.
- `flush` in 1: redirect; discard queue and issue registers.
- `issue1_valid`, `issue2_valid` out 1: slot valid (registered).
- `issue1_instr`, `issue2_instr` out 32: slot instructions (registered).
- `issue1_pc`, `issue2_pc` out 32: slot PCs (registered).
- `count` out log2(DEPTH)+1: current occupancy.
- `split_count` out 32: number of cycles where ≥2 entries were present but only one was issued.

## Operation
- Entry = {instr[31:0], pc[31:0]}. Head pointer, tail pointer and occupancy are registered.
- Enqueue when `in_valid1 & in_ready & ~flush`:
  - write instr1 at tail;
  - if `in_valid2`, also write instr2 at tail+1;
  - tail and occupancy advance by 1 or 2.
- Instruction classes, by opcode [31:26] and funct [5:0]:
  - control: opcode 0x04 (beq), 0x05 (bne), 0x02 (j), 0x03 (jal), or opcode 0 with funct 0x08 (jr);
  - memory: opcode 0x23 (lw), 0x2B (sw).
- Destination register:
  - opcode 0 and funct≠0x08 → rd [15:11];
  - opcode 0x03 → 31;
  - opcode 0x23 or 0x08–0x0F → rt [20:16];
  - otherwise none. A destination of 0 counts as none.
- Pairing: the head entry (A) and next entry (B) issue together only if all of the following hold:
  - occupancy ≥2;
  - A is not control and B is not control;
  - A and B are not both memory;
  - if A has a destination d, then rs[25:21] of B ≠ d and rt[20:16] of B ≠ d (conservative: both fields compared for every type);
  - A and B do not have the same destination.
- Issue update, when `~stall & ~flush`:
  - occupancy 0 → both valids 0 (bubble).
  - Paired → slot 1 ← A, slot 2 ← B, both valid; head +2.
  - Otherwise → slot 1 ← A valid, `issue2_valid`=0; head +1.
  - If occupancy was ≥2 and the pair was rejected, `split_count` +1.
- `stall`: all issue registers hold, head does not move, `split_count` holds. Enqueue still allowed.
- `flush`:
  - head, tail and occupancy ← 0; both issue valids ← 0;
  - any same-cycle enqueue is dropped;
  - `split_count` is not cleared.
- Priority: `rst` > `flush` > `stall`.
- Occupancy next = occupancy + enqueued − dequeued; enqueue and dequeue may happen in the same cycle.
- Pointers wrap modulo DEPTH.
- `issue*_instr`/`pc` contents are don't-care while the matching valid is 0 (bench must not check them).

## Timing
- Reset values: head, tail, occupancy, `count`, `split_count` = 0; `issue1_valid`, `issue2_valid` = 0; instr/pc registers = 0; `in_ready` = 1.
- Latency: an instruction written on edge E can appear on the issue ports after edge E+1 at the earliest.
- `in_ready` reflects occupancy after the previous edge. Same-cycle dequeue does not raise it.
- Full (occupancy ≥ DEPTH−1): `in_ready`=0; inputs are ignored and not lost by the block (the fetch side holds them).
- `split_count` wraps from 0xFFFFFFFF to 0.
- Reset or flush mid-stream leaves no stale valid on the following cycle.

## Test plan
- Reset, then enqueue 0x00221820 (add $3,$1,$2) + 0x00223020 (add $6,$1,$2) at pc 0x100 → next-next cycle: both valid, pcs 0x100/0x104, `split_count`=0.
- Enqueue 0x00221820 + 0x00642820 (RAW on $3) → slot 1 alone, then slot 1 = 0x00642820 at pc 0x104 the next cycle; `split_count`=1.
- Enqueue 0x8D280000 (lw) + 0xAD480004 (sw) → issued singly over two cycles, `split_count`=1. Also: 0x10220004 (beq) followed by an independent add → beq issued alone.
- Fill with `stall`=1 until `in_ready`=0 (`count`=7 or 8 for DEPTH 8) → no overflow, issue outputs frozen. Release `stall` → in-order drain; pointer wrap-around verified.
- Assert `flush` with 5 entries queued plus a same-cycle enqueue → next cycle `count`=0, both valids 0, `split_count` unchanged.
- Assert `rst` mid-stream with `stall`=1 → all outputs return to reset values on the next cycle.
